// File: rtl/qam16_pkg.sv
// Shared definitions for the QAM16 frame synchroniser: FSM encodings,
// default sync pattern and small helpers.
package qam16_pkg;

    // Synchroniser states; encodings are visible to the host on state_o.
    typedef enum logic [1:0] {
        ST_HUNT   = 2'b00,
        ST_VERIFY = 2'b01,
        ST_LOCK   = 2'b10
    } state_e;

    localparam logic [15:0] DEFAULT_SYNC_WORD = 16'hEB90;

    // Wide enough for a frame position up to 4 + 2*255 - 1 = 513.
    localparam int unsigned POS_W = 10;

    // Saturating 8-bit increment for host-visible event counters.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/qam16_nibble_packer.sv
// Pairs payload nibbles into bytes (first nibble in the high half) and
// presents each byte with a one-cycle registered strobe.
module qam16_nibble_packer
    import qam16_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       nib_en,      // payload nibble present this cycle
    input  logic [3:0] nib,
    input  logic       nib_odd,     // 1: low nibble of a byte
    input  logic       first_byte,  // this pair forms byte index 0 of the frame
    input  logic       flush,       // drop any half-assembled byte
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       frame_start
);

    logic [3:0] hi_q;
    logic       hi_vld_q;
    logic [7:0] byte_q;
    logic       vld_q;
    logic       fs_q;

    // Latch high nibble, emit byte on the low nibble; flush wins over a new high nibble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q     <= 4'd0;
            hi_vld_q <= 1'b0;
            byte_q   <= 8'd0;
            vld_q    <= 1'b0;
            fs_q     <= 1'b0;
        end else begin
            vld_q <= 1'b0;
            fs_q  <= 1'b0;
            if (nib_en) begin
                if (!nib_odd) begin
                    hi_q     <= nib;
                    hi_vld_q <= 1'b1;
                end else if (hi_vld_q) begin
                    byte_q   <= {hi_q, nib};
                    vld_q    <= 1'b1;
                    fs_q     <= first_byte;
                    hi_vld_q <= 1'b0;
                end
            end
            if (flush) begin
                hi_vld_q <= 1'b0;
            end
        end
    end

    assign byte_out    = byte_q;
    assign byte_valid  = vld_q;
    assign frame_start = fs_q;

endmodule

// File: rtl/qam16_frame_sync.sv
// Frame synchroniser after the QAM16 demapper: sync-word search, verify and
// flywheel lock tracking, payload byte sequencing and lock-loss counting.
module qam16_frame_sync
    import qam16_pkg::*;
#(
    parameter logic [15:0] SYNC_WORD = DEFAULT_SYNC_WORD,
    parameter int unsigned FRAME_LEN = 62,
    parameter int unsigned VERIFY_N  = 2,
    parameter int unsigned MISS_N    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sym_en,
    input  logic [3:0] sym_in,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       frame_start,
    output logic       locked,
    output logic [1:0] state_o,
    output logic [7:0] lock_loss_cnt
);

    localparam int unsigned PAY_NIBS = 2 * FRAME_LEN;
    localparam int unsigned N_NIBS   = PAY_NIBS + 4;
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(N_NIBS - 1);
    localparam logic [POS_W-1:0] PAY_END  = POS_W'(PAY_NIBS);
    localparam logic [2:0] VERIFY_T = 3'(VERIFY_N);
    localparam logic [2:0] MISS_T   = 3'(MISS_N);

    state_e           state_q, state_d;
    // Only the previous three nibbles are needed to form the 16-bit compare window.
    logic [11:0]      sreg_q, sreg_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic [2:0]       hits_q, hits_d;
    logic [2:0]       miss_q, miss_d;
    logic [7:0]       loss_q, loss_d;

    logic [15:0]      window;
    logic             match;
    logic             at_last;
    logic [POS_W-1:0] pos_inc;

    assign window  = {sreg_q, sym_in};
    assign match   = (window == SYNC_WORD);
    assign at_last = (pos_q == POS_LAST);
    assign pos_inc = at_last ? '0 : pos_q + 1'b1;

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_HUNT;
            sreg_q  <= '0;
            pos_q   <= '0;
            hits_q  <= '0;
            miss_q  <= '0;
            loss_q  <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            pos_q   <= pos_d;
            hits_q  <= hits_d;
            miss_q  <= miss_d;
            loss_q  <= loss_d;
        end
    end

    // Hunt/verify/lock transitions; nothing moves without a symbol strobe.
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        pos_d   = pos_q;
        hits_d  = hits_q;
        miss_d  = miss_q;
        loss_d  = loss_q;
        if (sym_en) begin
            sreg_d = window[11:0];
            unique case (state_q)
                ST_HUNT: begin
                    if (match) begin
                        pos_d   = '0;
                        hits_d  = 3'd1;
                        miss_d  = '0;
                        state_d = (VERIFY_T == 3'd1) ? ST_LOCK : ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    pos_d = pos_inc;
                    if (at_last) begin
                        if (match) begin
                            hits_d = hits_q + 3'd1;
                            if (hits_q + 3'd1 >= VERIFY_T) begin
                                state_d = ST_LOCK;
                                miss_d  = '0;
                            end
                        end else begin
                            // Current nibble is not re-examined for a fresh sync.
                            state_d = ST_HUNT;
                            hits_d  = '0;
                        end
                    end
                end
                ST_LOCK: begin
                    pos_d = pos_inc;
                    if (at_last) begin
                        if (match) begin
                            miss_d = '0;
                        end else if (miss_q + 3'd1 >= MISS_T) begin
                            state_d = ST_HUNT;
                            miss_d  = '0;
                            hits_d  = '0;
                            loss_d  = sat_inc8(loss_q);
                        end else begin
                            // Flywheel: keep frame timing through a missed sync.
                            miss_d = miss_q + 3'd1;
                        end
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end
    end

    logic pk_en;
    logic pk_first;
    logic pk_flush;

    assign pk_en    = sym_en && (state_q == ST_LOCK) && (pos_q < PAY_END);
    assign pk_first = (pos_q == POS_W'(1));
    assign pk_flush = (state_q == ST_LOCK) && (state_d != ST_LOCK);

    qam16_nibble_packer u_packer (
        .clk         (clk),
        .rst         (rst),
        .nib_en      (pk_en),
        .nib         (sym_in),
        .nib_odd     (pos_q[0]),
        .first_byte  (pk_first),
        .flush       (pk_flush),
        .byte_out    (byte_out),
        .byte_valid  (byte_valid),
        .frame_start (frame_start)
    );

    assign locked        = (state_q == ST_LOCK);
    assign state_o       = state_q;
    assign lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_qam16_frame_sync.sv
// Directed bench for qam16_frame_sync (FRAME_LEN=4, VERIFY_N=2, MISS_N=3).
// Expected bytes go into a queue as stimulus is issued; a monitor thread pops
// and compares whenever byte_valid is seen.
module tb_qam16_frame_sync;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sym_en = 1'b0;
    logic [3:0] sym_in = 4'd0;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       frame_start;
    logic       locked;
    logic [1:0] state_o;
    logic [7:0] lock_loss_cnt;

    int checks = 0;
    int failures = 0;
    logic [8:0] exp_q[$];  // {frame_start, byte}
    logic en_at_edge = 1'b0;
    int gap_on = 0;
    int gcnt = 0;

    always #5 clk = ~clk;

    // Remember whether the bench strobed a symbol at the last active edge.
    always @(posedge clk) en_at_edge <= sym_en;

    qam16_frame_sync #(
        .SYNC_WORD (16'hEB90),
        .FRAME_LEN (4),
        .VERIFY_N  (2),
        .MISS_N    (3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .sym_en        (sym_en),
        .sym_in        (sym_in),
        .byte_out      (byte_out),
        .byte_valid    (byte_valid),
        .frame_start   (frame_start),
        .locked        (locked),
        .state_o       (state_o),
        .lock_loss_cnt (lock_loss_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One symbol strobe, then optional idle cycles; entered and left at a negedge.
    task automatic send(input logic [3:0] n);
        int gap;
        gap = 0;
        if (gap_on != 0) begin
            gap = gcnt % 6;
            gcnt++;
        end
        sym_in = n;
        sym_en = 1'b1;
        @(negedge clk);
        sym_en = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_word(input logic [15:0] w);
        for (int i = 3; i >= 0; i--) send(w[i*4 +: 4]);
    endtask

    task automatic send_payload(input logic [31:0] p);
        for (int i = 7; i >= 0; i--) send(p[i*4 +: 4]);
    endtask

    task automatic frame(input logic [31:0] p, input logic [15:0] sync);
        send_payload(p);
        send_word(sync);
    endtask

    task automatic exp4(input logic [7:0] b0, input logic [7:0] b1,
                        input logic [7:0] b2, input logic [7:0] b3);
        exp_q.push_back({1'b1, b0});
        exp_q.push_back({1'b0, b1});
        exp_q.push_back({1'b0, b2});
        exp_q.push_back({1'b0, b3});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, 32'(state_o), 32'd0);
        check({tag, "_locked"}, 32'(locked), 32'd0);
        check({tag, "_loss"}, 32'(lock_loss_cnt), 32'd0);
        check({tag, "_byte_valid"}, 32'(byte_valid), 32'd0);
        check({tag, "_frame_start"}, 32'(frame_start), 32'd0);
        check({tag, "_byte_out"}, 32'(byte_out), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        fork
            forever begin
                logic [8:0] e;
                @(negedge clk);
                if (!rst && byte_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_byte: got 0x%0h expected no byte", byte_out);
                    end else begin
                        e = exp_q.pop_front();
                        check("byte_out", 32'(byte_out), 32'(e[7:0]));
                        check("frame_start", 32'(frame_start), 32'(e[8]));
                        check("byte_timing", 32'(en_at_edge), 32'd1);
                    end
                end
            end
        join_none

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst = 1'b0;
        @(negedge clk);

        // Acquisition: noise with a near-miss, then two good syncs one frame apart.
        send(4'h3); send(4'h7); send(4'hE); send(4'hB); send(4'h9); send(4'h1);
        check("hunt_no_false_sync", 32'(state_o), 32'd0);
        send_word(16'hEB90);
        check("verify_after_sync1", 32'(state_o), 32'd1);
        send_payload(32'hAAAA_AAAA);
        send_word(16'hEB90);
        check("lock_after_sync2_state", 32'(state_o), 32'd2);
        check("lock_after_sync2_locked", 32'(locked), 32'd1);

        // Locked payload.
        exp4(8'h12, 8'h34, 8'h56, 8'h78);
        frame(32'h1234_5678, 16'hEB90);
        check("locked_frame1", 32'(locked), 32'd1);

        // Two misses, then a good sync: flywheel keeps lock.
        exp4(8'h9A, 8'hBC, 8'hDE, 8'hF0);
        frame(32'h9ABC_DEF0, 16'h0000);
        check("flywheel_miss1", 32'(locked), 32'd1);
        exp4(8'h11, 8'h22, 8'h33, 8'h44);
        frame(32'h1122_3344, 16'hEB91);
        check("flywheel_miss2", 32'(locked), 32'd1);
        exp4(8'hAB, 8'hCD, 8'hEF, 8'h01);
        frame(32'hABCD_EF01, 16'hEB90);
        check("flywheel_recover", 32'(locked), 32'd1);
        check("no_loss_yet", 32'(lock_loss_cnt), 32'd0);

        // Three misses in a row drop lock.
        exp4(8'h01, 8'h23, 8'h45, 8'h67);
        frame(32'h0123_4567, 16'h0000);
        exp4(8'h89, 8'hAB, 8'hCD, 8'hEF);
        frame(32'h89AB_CDEF, 16'h1111);
        check("still_locked_miss2", 32'(locked), 32'd1);
        exp4(8'h55, 8'h66, 8'h77, 8'h88);
        frame(32'h5566_7788, 16'h2222);
        check("lost_state", 32'(state_o), 32'd0);
        check("lost_locked", 32'(locked), 32'd0);
        check("lost_count", 32'(lock_loss_cnt), 32'd1);
        send_payload(32'h1234_5678);
        check("hunt_quiet", 32'(state_o), 32'd0);

        // Verify failure on a one-bit-off sync word.
        send_word(16'hEB90);
        check("verify_again", 32'(state_o), 32'd1);
        send_payload(32'hCCCC_CCCC);
        send_word(16'hEB91);
        check("verify_fail_hunt", 32'(state_o), 32'd0);
        check("verify_fail_count", 32'(lock_loss_cnt), 32'd1);

        // Same acquisition with 0..5 idle cycles between strobes.
        gap_on = 1;
        send(4'h3);
        send_word(16'hEB90);
        check("gap_verify", 32'(state_o), 32'd1);
        send_payload(32'h0000_0000);
        send_word(16'hEB90);
        check("gap_lock", 32'(state_o), 32'd2);
        exp4(8'h12, 8'h34, 8'h56, 8'h78);
        frame(32'h1234_5678, 16'hEB90);
        check("gap_locked_after", 32'(locked), 32'd1);
        gap_on = 0;

        // Asynchronous reset in the middle of a locked frame.
        exp_q.push_back({1'b1, 8'h9A});
        send(4'h9); send(4'hA); send(4'hB);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_hunt", 32'(state_o), 32'd0);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
